// File: rtl/tx_lane_gearbox_if.sv
// Link-side lane bundle for tx_lane_gearbox: word handshake, lane enable, serializer word, underflow status.
// master = link layer driving words in; slave = gearbox.
`ifndef SERDES_STAGES
`define SERDES_STAGES 4
`endif

interface tx_lane_gearbox_if #(
    parameter int IN_W  = 64,
    parameter int OUT_W = 2**`SERDES_STAGES
);
    logic             tx_en;
    logic [IN_W-1:0]  in_data;
    logic             in_valid;
    logic             in_ready;
    logic [OUT_W-1:0] tx_din;
    logic             underflow;
    logic             clr_uf;

    modport master (
        output tx_en, in_data, in_valid, clr_uf,
        input  in_ready, tx_din, underflow
    );

    modport slave (
        input  tx_en, in_data, in_valid, clr_uf,
        output in_ready, tx_din, underflow
    );
endinterface

// File: rtl/tx_lane_gearbox.sv
// Purpose: slices IN_W link words into OUT_W serializer words (LSB slice first), idles and flags underflow; TX_PRBS_EN adds a PRBS7 source.
// Latency: word accepted at edge N shows slice 0 on tx_din after edge N+1; tx_din is a pure register output.
// Backpressure: in_ready = tx_en & ~nxt_valid (no in_valid path); one holding word keeps the stream gapless.
`ifndef SERDES_STAGES
`define SERDES_STAGES 4
`endif

module tx_lane_gearbox #(
    parameter int               IN_W         = 64,
    parameter int               OUT_W        = 2**`SERDES_STAGES,
    parameter logic [OUT_W-1:0] IDLE_PATTERN = {OUT_W{1'b0}}
) (
    input  logic             clk,
    input  logic             rstb,
`ifdef TX_PRBS_EN
    input  logic             prbs_en,
`endif
    tx_lane_gearbox_if.slave lane
);
    localparam int              R     = IN_W / OUT_W;
    localparam int              CNT_W = $clog2(R);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(R - 1);

    logic [IN_W-1:0]  cur_q, cur_d;
    logic [IN_W-1:0]  nxt_q, nxt_d;
    logic             cur_valid_q, cur_valid_d;
    logic             nxt_valid_q, nxt_valid_d;
    logic             active_q, active_d;
    logic [CNT_W-1:0] slice_cnt_q, slice_cnt_d;
    logic [OUT_W-1:0] tx_din_q, tx_din_d;
    logic             underflow_q, underflow_d;

    logic prbs_on;
    logic flush;
    logic in_ready;
    logic accept;
    logic uf_set;

`ifdef TX_PRBS_EN
    logic [6:0]       lfsr_q, lfsr_d;
    logic [OUT_W-1:0] prbs_word;

    assign prbs_on = prbs_en & lane.tx_en;

    // x^7+x^6+1: each new bit is the XOR of the bits 7 and 6 steps back; bit 0 is the oldest of the word.
    always_comb begin
        logic [6:0] s;
        s         = lfsr_q;
        prbs_word = '0;
        for (int i = 0; i < OUT_W; i++) begin
            prbs_word[i] = s[6] ^ s[5];
            s            = {s[5:0], s[6] ^ s[5]};
        end
        lfsr_d = prbs_on ? s : lfsr_q;
    end
`else
    assign prbs_on = 1'b0;
`endif

    assign flush    = ~lane.tx_en | prbs_on;
    assign in_ready = rstb & lane.tx_en & ~nxt_valid_q & ~prbs_on;
    assign accept   = lane.in_valid & in_ready;

    always_comb begin
        cur_d       = cur_q;
        nxt_d       = nxt_q;
        cur_valid_d = cur_valid_q;
        nxt_valid_d = nxt_valid_q;
        active_d    = active_q;
        slice_cnt_d = slice_cnt_q;
        tx_din_d    = tx_din_q;
        uf_set      = 1'b0;

        if (flush) begin
            cur_valid_d = 1'b0;
            nxt_valid_d = 1'b0;
            active_d    = 1'b0;
            slice_cnt_d = '0;
`ifdef TX_PRBS_EN
            tx_din_d    = prbs_on ? prbs_word : IDLE_PATTERN;
`else
            tx_din_d    = IDLE_PATTERN;
`endif
        end else if (cur_valid_q) begin
            tx_din_d = cur_q[int'(slice_cnt_q) * OUT_W +: OUT_W];
            if (slice_cnt_q == LAST) begin
                slice_cnt_d = '0;
                if (nxt_valid_q) begin
                    cur_d       = nxt_q;
                    nxt_valid_d = 1'b0;
                end else if (accept) begin
                    cur_d = lane.in_data;
                end else begin
                    cur_valid_d = 1'b0;
                    uf_set      = active_q;
                    active_d    = 1'b0;
                end
            end else begin
                slice_cnt_d = slice_cnt_q + CNT_W'(1);
                // accept implies nxt was empty, so it can always park here
                if (accept) begin
                    nxt_d       = lane.in_data;
                    nxt_valid_d = 1'b1;
                end
            end
        end else begin
            tx_din_d = IDLE_PATTERN;
            if (accept) begin
                cur_d       = lane.in_data;
                cur_valid_d = 1'b1;
                slice_cnt_d = '0;
                active_d    = 1'b1;
            end
        end

        // a set on the same edge as clr_uf wins
        underflow_d = uf_set | (underflow_q & ~lane.clr_uf);
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cur_q       <= '0;
            nxt_q       <= '0;
            cur_valid_q <= 1'b0;
            nxt_valid_q <= 1'b0;
            active_q    <= 1'b0;
            slice_cnt_q <= '0;
            tx_din_q    <= IDLE_PATTERN;
            underflow_q <= 1'b0;
        end else begin
            cur_q       <= cur_d;
            nxt_q       <= nxt_d;
            cur_valid_q <= cur_valid_d;
            nxt_valid_q <= nxt_valid_d;
            active_q    <= active_d;
            slice_cnt_q <= slice_cnt_d;
            tx_din_q    <= tx_din_d;
            underflow_q <= underflow_d;
        end
    end

`ifdef TX_PRBS_EN
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            lfsr_q <= 7'h7F;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`endif

    assign lane.in_ready  = in_ready;
    assign lane.tx_din    = tx_din_q;
    assign lane.underflow = underflow_q;
endmodule

// File: tb/tb_tx_lane_gearbox.sv
// Bench for tx_lane_gearbox (IN_W=64, OUT_W=16): directed steps plus random traffic against a slice-queue model.
// PRBS7 steps are built only when TX_PRBS_EN is defined.
module tb_tx_lane_gearbox;
    localparam int IN_W  = 64;
    localparam int OUT_W = 16;
    localparam int R     = IN_W / OUT_W;

    logic clk = 1'b0;
    logic rstb;
`ifdef TX_PRBS_EN
    logic prbs_en;
`endif

    always #5 clk = ~clk;

    tx_lane_gearbox_if #(.IN_W(IN_W), .OUT_W(OUT_W)) lane ();

    tx_lane_gearbox #(
        .IN_W        (IN_W),
        .OUT_W       (OUT_W),
        .IDLE_PATTERN(16'h0000)
    ) dut (
        .clk    (clk),
        .rstb   (rstb),
`ifdef TX_PRBS_EN
        .prbs_en(prbs_en),
`endif
        .lane   (lane)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Model: every accepted word becomes R queued slices; one slice leaves per enabled edge.
    logic [OUT_W-1:0] mq[$];
    logic [OUT_W-1:0] exp_dout;
    logic             exp_uf;
    bit               last_acc;
    bit               ph[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit prbs_mode();
`ifdef TX_PRBS_EN
        return prbs_en;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit exp_ready();
        return rstb && lane.tx_en && !prbs_mode() && (mq.size() <= R);
    endfunction

    task automatic model_reset();
        mq.delete();
        exp_dout = '0;
        exp_uf   = 1'b0;
        last_acc = 1'b0;
        ph.delete();
        repeat (7) ph.push_back(1'b1);
    endtask

    task automatic tick();
        bit acc;
        bit set;
        bit b;
        #2;
        chk("in_ready", {63'd0, lane.in_ready}, {63'd0, exp_ready()});
        acc = lane.in_valid && exp_ready();
        @(posedge clk);
        set = 1'b0;
        if (!lane.tx_en) begin
            mq.delete();
            exp_dout = '0;
        end else if (prbs_mode()) begin
            mq.delete();
            for (int i = 0; i < OUT_W; i++) begin
                b = ph[0] ^ ph[1];
                exp_dout[i] = b;
                ph.push_back(b);
                void'(ph.pop_front());
            end
        end else begin
            if (mq.size() > 0) begin
                exp_dout = mq.pop_front();
                if (mq.size() == 0 && !acc) set = 1'b1;
            end else begin
                exp_dout = '0;
            end
            if (acc) begin
                for (int k = 0; k < R; k++) mq.push_back(lane.in_data[k*OUT_W +: OUT_W]);
            end
        end
        exp_uf   = set | (exp_uf & ~lane.clr_uf);
        last_acc = acc;
        #1;
        chk("tx_din", {48'd0, lane.tx_din}, {48'd0, exp_dout});
        chk("underflow", {63'd0, lane.underflow}, {63'd0, exp_uf});
    endtask

    function automatic logic [IN_W-1:0] rnd_word_nz();
        return {$urandom, $urandom} | 64'h0001_0001_0001_0001;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [OUT_W-1:0] t2[4];
        logic [IN_W-1:0]  w2;
        int               words;
        int               run;
        int               maxrun;

        t2 = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        rstb          = 1'b0;
        lane.tx_en    = 1'b1;
        lane.in_valid = 1'b0;
        lane.in_data  = '0;
        lane.clr_uf   = 1'b0;
`ifdef TX_PRBS_EN
        prbs_en = 1'b0;
`endif
        model_reset();

        // Reset holds outputs idle regardless of tx_en
        repeat (5) begin
            @(negedge clk);
            chk("rst_tx_din", {48'd0, lane.tx_din}, 64'd0);
            chk("rst_in_ready", {63'd0, lane.in_ready}, 64'd0);
            chk("rst_underflow", {63'd0, lane.underflow}, 64'd0);
        end
        @(posedge clk);
        #1 rstb = 1'b1;

        // Idle after reset
        repeat (3) tick();
        chk("idle_ready", {63'd0, lane.in_ready}, 64'd1);

        // Single word, then underflow at stream end
        lane.in_data  = 64'h4444_3333_2222_1111;
        lane.in_valid = 1'b1;
        tick();
        lane.in_valid = 1'b0;
        for (int k = 0; k < R; k++) begin
            tick();
            chk("t2_slice", {48'd0, lane.tx_din}, {48'd0, t2[k]});
        end
        tick();
        chk("t2_idle", {48'd0, lane.tx_din}, 64'd0);
        chk("t2_uf", {63'd0, lane.underflow}, 64'd1);
        lane.clr_uf = 1'b1;
        tick();
        lane.clr_uf = 1'b0;
        chk("t2_uf_clr", {63'd0, lane.underflow}, 64'd0);

        // Back-to-back 8 words with in_valid held high
        words = 0; run = 0; maxrun = 0;
        lane.in_data  = rnd_word_nz();
        lane.in_valid = 1'b1;
        for (int c = 0; c < 100 && words < 8; c++) begin
            tick();
            if (lane.tx_din != 0) begin run++; if (run > maxrun) maxrun = run; end
            else run = 0;
            if (last_acc) begin
                words++;
                lane.in_data = rnd_word_nz();
            end
        end
        lane.in_valid = 1'b0;
        repeat (10) begin
            tick();
            if (lane.tx_din != 0) begin run++; if (run > maxrun) maxrun = run; end
            else run = 0;
        end
        chk("t3_words", 64'(words), 64'd8);
        chk("t3_gapless", 64'(maxrun), 64'd32);

        // tx_en dropped after slice 1 discards the rest of the word
        lane.in_data  = rnd_word_nz();
        lane.in_valid = 1'b1;
        tick();
        lane.in_valid = 1'b0;
        tick();
        tick();
        lane.tx_en = 1'b0;
        tick();
        chk("t5_flush", {48'd0, lane.tx_din}, 64'd0);
        tick();
        tick();
        lane.tx_en    = 1'b1;
        w2            = rnd_word_nz();
        lane.in_data  = w2;
        lane.in_valid = 1'b1;
        tick();
        lane.in_valid = 1'b0;
        tick();
        chk("t5_slice0", {48'd0, lane.tx_din}, {48'd0, w2[15:0]});
        repeat (5) tick();

        // Asynchronous reset mid-word
        lane.in_data  = rnd_word_nz();
        lane.in_valid = 1'b1;
        tick();
        lane.in_valid = 1'b0;
        tick();
        #2 rstb = 1'b0;
        #1;
        chk("arst_tx_din", {48'd0, lane.tx_din}, 64'd0);
        chk("arst_ready", {63'd0, lane.in_ready}, 64'd0);
        model_reset();
        @(posedge clk);
        #1 rstb = 1'b1;
        repeat (4) tick();

        // Random traffic, enable drops and underflow clears
        for (int c = 0; c < 600; c++) begin
            lane.tx_en    = ($urandom % 20) != 0;
            lane.in_valid = ($urandom % 10) < 7;
            lane.in_data  = {$urandom, $urandom};
            lane.clr_uf   = ($urandom % 8) == 0;
            tick();
        end
        lane.tx_en    = 1'b1;
        lane.in_valid = 1'b0;
        lane.clr_uf   = 1'b0;
        repeat (8) tick();

`ifdef TX_PRBS_EN
        // PRBS7 from reset, with link traffic present but refused
        rstb          = 1'b0;
        prbs_en       = 1'b1;
        lane.in_valid = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rstb = 1'b1;
        tick();
        chk("prbs_first", {48'd0, lane.tx_din}, 64'h3040);
        repeat (126) tick();
        tick();
        chk("prbs_repeat", {48'd0, lane.tx_din}, 64'h3040);
        prbs_en       = 1'b0;
        lane.in_valid = 1'b0;
        tick();
        chk("prbs_off_idle", {48'd0, lane.tx_din}, 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
